lsu_ctrl: RTL and testbench

Load/store sequencer between the MEM stage and the single-ported 32-bit data memory. Turns one load or store request into one or two word-aligned memory beats with byte enables, splitting accesses that cross a word boundary. Stalls the pipeline until done and returns a fully aligned, sign- or zero-extended load result.

---
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: splits unaligned accesses into one or two
// word beats and returns an aligned, extended load result.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, REQ0, RSP0, REQ1, RSP1, DONE
    } state_t;

    state_t state, state_n;

    logic        active;
    logic        legal;
    logic        ld_ok;
    logic        st_ok;
    logic [3:0]  mask;
    logic [7:0]  be8;
    logic [63:0] wd64;

    logic        err_q;
    logic        st_q;
    logic        split_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] base_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;
    logic [31:0] algn;
    logic [31:0] ext;

    assign active = req_valid & (req_load | req_store);
    assign ld_ok  = (req_funct3 != 3'd3) & (req_funct3 <= 3'd5);
    assign st_ok  = (req_funct3 <= 3'd2);
    assign legal  = (req_load & ~req_store & ld_ok)
                  | (req_store & ~req_load & st_ok);

    always_comb begin
        mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign be8  = {4'b0000, mask} << req_addr[1:0];
    assign wd64 = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (active) state_n = legal ? REQ0 : DONE;
            REQ0: if (mem_gnt) begin
                if (!st_q)        state_n = RSP0;
                else if (split_q) state_n = REQ1;
                else              state_n = DONE;
            end
            RSP0: if (mem_rvalid) state_n = split_q ? REQ1 : DONE;
            REQ1: if (mem_gnt) state_n = st_q ? DONE : RSP1;
            RSP1: if (mem_rvalid) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            err_q     <= 1'b0;
            st_q      <= 1'b0;
            split_q   <= 1'b0;
            off_q     <= 2'd0;
            f3_q      <= 3'd0;
            base_q    <= 32'h0;
            be_hi_q   <= 4'h0;
            wd_hi_q   <= 32'h0;
            lo_q      <= 32'h0;
            hi_q      <= 24'h0;
        end else begin
            state   <= state_n;
            mem_req <= (state_n == REQ0) | (state_n == REQ1);
            if (state == IDLE && active) begin
                err_q   <= ~legal;
                st_q    <= req_store;
                split_q <= |be8[7:4];
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                base_q  <= {req_addr[31:2], 2'b00};
                be_hi_q <= be8[7:4];
                wd_hi_q <= wd64[63:32];
                lo_q    <= 32'h0;
                hi_q    <= 24'h0;
                if (legal) begin
                    mem_we    <= req_store;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_be    <= be8[3:0];
                    mem_wdata <= wd64[31:0];
                end
            end
            // second beat is loaded on entry to REQ1
            if (state_n == REQ1 && state != REQ1) begin
                mem_addr  <= base_q + 32'd4;
                mem_be    <= be_hi_q;
                mem_wdata <= wd_hi_q;
            end
            if (state == RSP0 && mem_rvalid) lo_q <= mem_rdata;
            if (state == RSP1 && mem_rvalid) hi_q <= mem_rdata[23:0];
        end
    end

    always_comb begin
        algn = lo_q;
        case (off_q)
            2'd0: algn = lo_q;
            2'd1: algn = {hi_q[7:0],  lo_q[31:8]};
            2'd2: algn = {hi_q[15:0], lo_q[31:16]};
            2'd3: algn = {hi_q[23:0], lo_q[31:24]};
            default: algn = lo_q;
        endcase
    end

    always_comb begin
        ext = algn;
        case (f3_q)
            3'd0:    ext = {{24{algn[7]}}, algn[7:0]};
            3'd1:    ext = {{16{algn[15]}}, algn[15:0]};
            3'd4:    ext = {24'h0, algn[7:0]};
            3'd5:    ext = {16'h0, algn[15:0]};
            default: ext = algn;
        endcase
    end

    assign stall     = active & (state != DONE);
    assign rsp_valid = (state == DONE);
    assign rsp_err   = (state == DONE) & err_q;
    assign rsp_data  = (state == DONE && !st_q && !err_q) ? ext : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests, a memory
// responder that checks beats, and a monitor that checks responses.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    beat_t       bq[$];
    rsp_t        rq[$];
    logic [31:0] mem [logic [31:0]];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          gnt_delay = 0;
    int          rv_lat = 1;
    int          rv_cnt = 0;
    int          wait_cnt = 0;
    logic [31:0] rv_data = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be,
                             input logic we, input logic [31:0] wd);
        beat_t b;
        b.addr = a;
        b.be = be;
        b.we = we;
        b.wdata = we ? wd : 32'h0;
        bq.push_back(b);
    endtask

    // memory responder: grants after gnt_delay, read data rv_lat later
    initial begin
        beat_t b;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rv_data;
                end
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                    if (bq.size() > 0)
                        chk("beat_hold", {mem_addr, mem_be},
                            {bq[0].addr, bq[0].be});
                end else begin
                    wait_cnt = 0;
                    mem_gnt = 1'b1;
                    if (bq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_unexpected: addr %h be %b",
                                 mem_addr, mem_be);
                    end else begin
                        b = bq.pop_front();
                        chk("beat", {mem_addr, mem_be, mem_we,
                                     mem_we ? mem_wdata : 32'h0},
                            {b.addr, b.be, b.we, b.wdata});
                    end
                    if (!mem_we) begin
                        rv_cnt = rv_lat;
                        rv_data = rd(mem_addr);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: data %h err %b",
                         rsp_data, rsp_err);
            end else begin
                e = rq.pop_front();
                chk("rsp", {rsp_err, rsp_data}, {e.err, e.data});
            end
        end
    end

    task automatic do_req(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] xd,
                          input logic xe, input int xstall);
        rsp_t e;
        int n;
        e.data = xd;
        e.err = xe;
        rq.push_back(e);
        @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_load = ld;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk);
            #3;
        end
        req_valid = 1'b0;
        chk("stall_cycles", 72'(n), 72'(xstall));
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_load = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        mem[32'h300] = 32'hDEADBEEF;
        mem[32'h100] = 32'h80123456;
        mem[32'h104] = 32'hABCDEFFF;
        mem[32'h000] = 32'h12348A56;

        #2 rst_n = 1'b0;
        #3;
        chk("reset_outs", {stall, rsp_valid, rsp_data, rsp_err, mem_req,
                           mem_we, mem_addr, mem_be, mem_wdata}, 72'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        push_beat(32'h300, 4'b1111, 1'b0, 32'h0);
        do_req(1, 0, 3'd2, 32'h300, 0, 32'hDEADBEEF, 0, 3);

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
        do_req(1, 0, 3'd1, 32'h103, 0, 32'hFFFFFF80, 0, 5);

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
        do_req(1, 0, 3'd5, 32'h103, 0, 32'h0000FF80, 0, 5);

        push_beat(32'h200, 4'b1100, 1'b1, 32'h33440000);
        push_beat(32'h204, 4'b0011, 1'b1, 32'h00001122);
        do_req(0, 1, 3'd2, 32'h202, 32'h11223344, 32'h0, 0, 3);

        push_beat(32'h004, 4'b1000, 1'b1, 32'hAB000000);
        do_req(0, 1, 3'd0, 32'h007, 32'h123456AB, 32'h0, 0, 2);

        push_beat(32'hFFFFFFFC, 4'b1000, 1'b1, 32'hEF000000);
        push_beat(32'h00000000, 4'b0001, 1'b1, 32'h000000BE);
        do_req(0, 1, 3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 0, 3);

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        do_req(1, 0, 3'd4, 32'h103, 0, 32'h00000080, 0, 3);

        push_beat(32'h100, 4'b1110, 1'b0, 32'h0);
        push_beat(32'h104, 4'b0001, 1'b0, 32'h0);
        do_req(1, 0, 3'd2, 32'h101, 0, 32'hFF801234, 0, 5);

        gnt_delay = 3;
        push_beat(32'h000, 4'b0010, 1'b0, 32'h0);
        do_req(1, 0, 3'd0, 32'h001, 0, 32'hFFFFFF8A, 0, 6);
        gnt_delay = 0;

        do_req(1, 0, 3'd3, 32'h100, 0, 32'h0, 1, 1);
        do_req(0, 1, 3'd4, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 1);
        do_req(1, 1, 3'd2, 32'h100, 0, 32'h0, 1, 1);

        // abandon a load in RSP0, then let stale read data arrive
        rv_lat = 3;
        push_beat(32'h300, 4'b1111, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_load = 1'b1;
        req_store = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h300;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        chk("rsp0_addr", {mem_req, mem_addr}, {1'b0, 32'h300});
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("midop_reset", {stall, rsp_valid, rsp_data, rsp_err, mem_req,
                            mem_we, mem_addr, mem_be, mem_wdata}, 72'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        rv_lat = 1;

        push_beat(32'h300, 4'b1111, 1'b0, 32'h0);
        do_req(1, 0, 3'd2, 32'h300, 0, 32'hDEADBEEF, 0, 3);

        repeat (5) @(posedge clk);
        #3;
        chk("beatq_empty", 72'(bq.size()), 72'h0);
        chk("rspq_empty", 72'(rq.size()), 72'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
